// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit: operation codes,
// FSM states and the pipeline stall constants.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } md_state_e;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // True for the four iterative operations; MTHI/MTLO and codes 6-7 are not.
  function automatic logic is_md_op(input logic [2:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Datapath of the muldiv unit: operand magnitudes, one shift-add or
// restoring-divide step per cycle, and the final two's-complement sign fix.
module muldiv_core
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic [2*WIDTH-1:0] acc_q, acc_nxt, prod;
  logic [WIDTH-1:0]   opnd_q, mag1, mag2, quo, rem;
  logic [WIDTH:0]     add_sum, rem_sh, rem_diff;
  logic               is_div_q, neg_lo_q, neg_hi_q, div0_q;
  logic               is_div_op, is_signed, s1, s2;

  always_comb begin
    is_div_op = (op == MD_DIV) || (op == MD_DIVU);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    s1        = is_signed & src1[WIDTH-1];
    s2        = is_signed & src2[WIDTH-1];
    mag1      = s1 ? -src1 : src1;
    mag2      = s2 ? -src2 : src2;
  end

  // Multiply keeps {partial product, unconsumed multiplier bits};
  // divide keeps {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      if (rem_sh >= {1'b0, opnd_q})
        acc_nxt = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Results are taken from acc_nxt so the top can write HI/LO on the last step edge.
  // A zero divisor leaves the dividend magnitude as remainder, so the sign fix
  // restores the raw dividend in HI.
  always_comb begin
    prod = neg_lo_q ? -acc_nxt : acc_nxt;
    quo  = acc_nxt[WIDTH-1:0];
    rem  = acc_nxt[2*WIDTH-1:WIDTH];
    if (is_div_q) begin
      res_lo = div0_q ? '1 : (neg_lo_q ? -quo : quo);
      res_hi = neg_hi_q ? -rem : rem;
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
    end else if (load) begin
      acc_q    <= {{WIDTH{1'b0}}, (is_div_op ? mag1 : mag2)};
      opnd_q   <= is_div_op ? mag2 : mag1;
      is_div_q <= is_div_op;
      neg_lo_q <= s1 ^ s2;
      neg_hi_q <= is_div_op & s1;
      div0_q   <= is_div_op && (src2 == '0);
    end else if (step) begin
      acc_q <= acc_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Execute-stage multiply/divide unit: FSM, iteration counter, pipeline
// handshake and the architectural HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             annul,
  input  logic             ex_advance,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] core_hi, core_lo;
  logic             md_req, accept, mt_write, last;

  always_comb begin
    md_req    = op_valid && is_md_op(op) && !annul;
    accept    = md_req && (state_q == ST_IDLE);
    mt_write  = op_valid && !annul && (state_q == ST_IDLE)
                && ((op == MD_MTHI) || (op == MD_MTLO));
    last      = (state_q == ST_BUSY) && (cnt_q == CNT_W'(WIDTH - 1));
    stall_req = (md_req && (state_q != ST_DONE)) ? STOP : NO_STOP;
    done      = (state_q == ST_DONE);
  end

  // NOTE: next state defaults to the current state first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_BUSY;
      ST_BUSY: begin
        if (annul)     state_d = ST_IDLE;
        else if (last) state_d = ST_DONE;
      end
      ST_DONE: if (annul || ex_advance) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      if (accept)                    cnt_q <= '0;
      else if (state_q == ST_BUSY)   cnt_q <= cnt_q + CNT_W'(1);
      // Annul on the final iteration suppresses the HI/LO write.
      if (last && !annul) begin
        hi <= core_hi;
        lo <= core_lo;
      end else if (mt_write) begin
        if (op == MD_MTHI) hi <= src1;
        else               lo <= src1;
      end
    end
  end

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .load   (accept),
    .step   (state_q == ST_BUSY),
    .op     (op),
    .src1   (src1),
    .src2   (src2),
    .res_hi (core_hi),
    .res_lo (core_lo)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        op_valid = 1'b0, annul = 1'b0, ex_advance = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        stall_req, done;
  logic [31:0] hi, lo;

  logic        op_valid8 = 1'b0, annul8 = 1'b0, ex_advance8 = 1'b0;
  logic [2:0]  op8 = 3'd0;
  logic [7:0]  src1_8 = '0, src2_8 = '0;
  logic        stall_req8, done8;
  logic [7:0]  hi8, lo8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op), .src1(src1), .src2(src2),
    .annul(annul), .ex_advance(ex_advance), .stall_req(stall_req), .done(done),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .resetn(resetn), .op_valid(op_valid8), .op(op8), .src1(src1_8), .src2(src2_8),
    .annul(annul8), .ex_advance(ex_advance8), .stall_req(stall_req8), .done(done8),
    .hi(hi8), .lo(lo8)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents an operation, counts stall cycles (bounded) and checks the result.
  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n;
    op_valid = 1'b1; op = o; src1 = a; src2 = b;
    #1;
    n = 0;
    while (stall_req && n < 200) begin
      n++;
      tick();
    end
    check({tag, " stalls"}, 32'(n), 32'd33);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " lo"}, lo, exp_lo);
  endtask

  task automatic retire();
    ex_advance = 1'b1;
    tick();
    ex_advance = 1'b0;
    op_valid   = 1'b0;
    #1;
    check("retire done", 32'(done), 32'd0);
  endtask

  task automatic run_md8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp_hi, input logic [7:0] exp_lo, input string tag);
    int n;
    op_valid8 = 1'b1; op8 = o; src1_8 = a; src2_8 = b;
    #1;
    n = 0;
    while (stall_req8 && n < 100) begin
      n++;
      tick();
    end
    check({tag, " stalls"}, 32'(n), 32'd9);
    check({tag, " done"}, 32'(done8), 32'd1);
    check({tag, " hi"}, 32'(hi8), 32'(exp_hi));
    check({tag, " lo"}, 32'(lo8), 32'(exp_lo));
    ex_advance8 = 1'b1;
    tick();
    ex_advance8 = 1'b0;
    op_valid8   = 1'b0;
    #1;
    check({tag, " retire"}, 32'(done8), 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    check("reset done", 32'(done), 32'd0);
    check("reset stall", 32'(stall_req), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    tick();

    run_md(MD_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3*7");
    retire();
    run_md(MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7");
    retire();
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    retire();
    run_md(MD_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, "div by 0");
    retire();
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div min/-1");
    retire();

    // MTHI: no stall, visible next cycle
    op_valid = 1'b1; op = MD_MTHI; src1 = 32'hDEAD_BEEF;
    #1;
    check("mthi stall", 32'(stall_req), 32'd0);
    tick();
    op_valid = 1'b0;
    #1;
    check("mthi hi", hi, 32'hDEAD_BEEF);
    check("mthi lo kept", lo, 32'h8000_0000);

    // Annul at iteration 10 of a MULTU
    op_valid = 1'b1; op = MD_MULTU; src1 = 32'd5; src2 = 32'd6;
    #1;
    repeat (11) tick();
    check("annul busy stall", 32'(stall_req), 32'd1);
    annul = 1'b1;
    #1;
    check("annul stall drop", 32'(stall_req), 32'd0);
    tick();
    annul = 1'b0; op_valid = 1'b0;
    #1;
    check("annul idle stall", 32'(stall_req), 32'd0);
    repeat (30) tick();
    check("annul done", 32'(done), 32'd0);
    check("annul hi kept", hi, 32'hDEAD_BEEF);
    check("annul lo kept", lo, 32'h8000_0000);

    // Asynchronous reset in the middle of a DIV
    op_valid = 1'b1; op = MD_DIV; src1 = 32'd100; src2 = 32'd7;
    #1;
    repeat (6) tick();
    resetn = 1'b0;
    #1;
    check("midreset hi", hi, 32'h0);
    check("midreset lo", lo, 32'h0);
    check("midreset done", 32'(done), 32'd0);
    op_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) tick();
    check("post reset lo", lo, 32'h0);

    // DONE hold with op_valid high, then back-to-back op
    run_md(MD_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h0, "multu 2^16*2^16");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold done", 32'(done), 32'd1);
      check("hold stall", 32'(stall_req), 32'd0);
    end
    ex_advance = 1'b1;
    tick();
    ex_advance = 1'b0;
    op = MD_DIVU; src1 = 32'd1000; src2 = 32'd10;
    #1;
    check("advance idle", 32'(done), 32'd0);
    run_md(MD_DIVU, 32'd1000, 32'd10, 32'd0, 32'd100, "b2b divu 1000/10");
    retire();

    // MTLO
    op_valid = 1'b1; op = MD_MTLO; src1 = 32'hA5A5_A5A5;
    #1;
    check("mtlo stall", 32'(stall_req), 32'd0);
    tick();
    op_valid = 1'b0;
    #1;
    check("mtlo lo", lo, 32'hA5A5_A5A5);
    check("mtlo hi kept", hi, 32'h0);

    // Annul in the acceptance cycle: no operation starts
    op_valid = 1'b1; op = MD_MULT; src1 = 32'd3; src2 = 32'd3; annul = 1'b1;
    #1;
    check("annul accept stall", 32'(stall_req), 32'd0);
    tick();
    op_valid = 1'b0; annul = 1'b0;
    repeat (36) tick();
    check("annul accept done", 32'(done), 32'd0);
    check("annul accept lo", lo, 32'hA5A5_A5A5);

    // Reserved op code is a no-op
    op_valid = 1'b1; op = 3'd6; src1 = 32'h1111_1111;
    #1;
    check("op6 stall", 32'(stall_req), 32'd0);
    tick();
    op_valid = 1'b0;
    #1;
    check("op6 hi", hi, 32'h0);
    check("op6 lo", lo, 32'hA5A5_A5A5);

    // Narrow instance
    run_md8(MD_MULT, 8'h80, 8'h80, 8'h40, 8'h00, "w8 mult 0x80*0x80");
    run_md8(MD_DIV, 8'hF9, 8'h02, 8'hFF, 8'hFD, "w8 div -7/2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width. It sits beside the ALU in the execute stage. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation from the EX pipeline register and holds the pipeline through `stall_req` until the result is ready. It supports flush (`annul`) and a well-defined divide-by-zero result, and it owns architectural HI/LO.

## Interface
- `WIDTH`, default 32: operand width, ≥4, even; HI/LO are each WIDTH bits.
- `CNT_W`, default $clog2(WIDTH)+1: iteration counter width (derived, not overridden).
- `clk` in 1: clock.
- `resetn` in 1: asynchronous, active-low reset.
- `op_valid` in 1: EX holds a muldiv-class instruction; held stable while `stall_req`=1.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 ignored (no-op).
- `src1` in WIDTH: multiplicand/dividend/MTxx data.
- `src2` in WIDTH: multiplier/divisor.
- `annul` in 1: flush; aborts any operation in progress.
- `ex_advance` in 1: EX→MEM register advances this cycle (stall[3]==NoStop).
- `stall_req` out 1: combinational; request pipeline stall.
- `done` out 1: result written this operation; high in DONE state.
- `hi` out WIDTH: HI register; remainder / high product.
- `lo` out WIDTH: LO register; quotient / low product.

## Operation
- States IDLE, BUSY, DONE. Reset → IDLE, counter 0, `hi`=`lo`=0, `done`=0.
- IDLE with `op_valid` & op∈{0..3} & !annul: latch operands, go BUSY, counter←0.
  - Signed ops latch magnitudes plus the sign-fix flags: neg_q = s1^s2 and neg_r = s1 for DIV; neg_p = s1^s2 for MULT.
  - Divisor 0: set div0 flag.
- IDLE with `op_valid` & MTHI/MTLO & !annul: write `hi`/`lo` ← src1 at the clock edge; no stall; state stays IDLE.
- BUSY: one iteration per cycle, WIDTH iterations, counter 0..WIDTH-1.
  - Multiply: shift-add into a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring radix-2 on magnitudes, one quotient bit per cycle, MSB first.
  - On the final iteration edge: apply two's-complement sign fix, write `hi`/`lo`, go DONE.
- DONE: `done`=1, `stall_req`=0. Go IDLE on `ex_advance` or `annul`; otherwise hold, and do not restart when `op_valid` stays high.
- `annul` in BUSY or DONE: go IDLE next edge; `hi`/`lo` unchanged unless already written in DONE.
- Divide by zero: `lo` ← all ones, `hi` ← src1 (raw, unsigned or signed). Full latency is still taken.
- Signed DIV MIN/−1: `lo` = MIN, `hi` = 0 (natural magnitude result; no trap).
- Remainder sign follows the dividend; quotient truncates toward zero.

## Timing
- `stall_req` = op_valid & op∈{0..3} & !annul & (state==IDLE | state==BUSY).
- Accept at cycle T: `stall_req` high T..T+WIDTH (WIDTH+1 cycles); `done` high from T+WIDTH+1.
- New `hi`/`lo` are visible from T+WIDTH+1.
- MTHI/MTLO accepted at T: the new value is visible at T+1.
- Back-to-back muldiv: after DONE→IDLE on `ex_advance`, the next op is accepted in the following IDLE cycle.
- `resetn` low at any time, including mid-BUSY: all state is cleared immediately with no HI/LO write. Outputs are at their reset values while `resetn` is low.
- `annul` and acceptance in the same cycle: `annul` wins; no operation starts.

## Structure
- Shared package/defines header: op encodings (MD_MULT..MD_MTLO), state encodings, and the `Stop`/`NoStop` constants already in the defines header.
- The sub-module `muldiv_core` (datapath: accumulator, shift/subtract step, sign fix) is natural. `muldiv_unit` keeps the FSM, counter, handshake and HI/LO registers.

## Test plan
- MULT src1=0xFFFFFFFD (−3), src2=7 → 33 stall cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done`=1.
- DIVU 100/7 → `lo`=14, `hi`=2. DIV −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIV 0x12345678/0 → `lo`=0xFFFFFFFF, `hi`=0x12345678 after full latency. DIV 0x80000000/−1 → `lo`=0x80000000, `hi`=0.
- MULTU started, `annul` at iteration 10 → IDLE next cycle, `stall_req`=0, `hi`/`lo` keep prior values. `resetn` pulse mid-DIV → `hi`=`lo`=0.
- DONE with `ex_advance`=0 for 3 cycles and `op_valid` held → no restart, `done` stays 1. `ex_advance`=1 → IDLE. MTLO 0xA5A5A5A5 then → `lo` updated next cycle, no stall.
- WIDTH=8 instance: MULT 0x80·0x80 → `hi`=0x40, `lo`=0x00, 9 stall cycles.
